// File: rtl/fas_pkg.sv
// fas_pkg: shared sizes, state encoding and bin-word field positions for the peak detector.
package fas_pkg;
    localparam int NBIN  = 16;
    localparam int DW    = 16;
    localparam int MAGW  = 32;
    localparam int RE_HI = 31;
    localparam int RE_LO = 16;
    localparam int IM_HI = 15;
    localparam int IM_LO = 0;
    typedef enum logic {IDLE, CALC} state_t;
endpackage

// File: rtl/fas_mag_sq.sv
// fas_mag_sq: combinational squared magnitude; i_re/i_im signed parts in, o_mag = re^2 + im^2 unsigned out.
module fas_mag_sq
    import fas_pkg::*;
(
    input  logic signed [DW-1:0]   i_re,
    input  logic signed [DW-1:0]   i_im,
    output logic        [MAGW-1:0] o_mag
);
    logic signed [2*DW-1:0] w_re2;
    logic signed [2*DW-1:0] w_im2;
    assign w_re2 = i_re * i_re;
    assign w_im2 = i_im * i_im;
    // Each square is non-negative and at most 2^30, so the sum always fits in 32 unsigned bits.
    assign o_mag = MAGW'($unsigned(w_re2)) + MAGW'($unsigned(w_im2));
endmodule

// File: rtl/fas_peak_detect.sv
// fas_peak_detect: finds the FFT bin with the largest squared magnitude in a 16-bin frame.
// Ports: clk, rst (async active-low), fft_valid + fft_d0..fft_d15 (frame in),
//        in_ready, busy, done (pulse), freq (peak bin), overrun (dropped-frame pulse).
module fas_peak_detect #(
    parameter int NBIN = 16,
    parameter int DW   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fft_valid,
    input  logic [2*DW-1:0]           fft_d0,
    input  logic [2*DW-1:0]           fft_d1,
    input  logic [2*DW-1:0]           fft_d2,
    input  logic [2*DW-1:0]           fft_d3,
    input  logic [2*DW-1:0]           fft_d4,
    input  logic [2*DW-1:0]           fft_d5,
    input  logic [2*DW-1:0]           fft_d6,
    input  logic [2*DW-1:0]           fft_d7,
    input  logic [2*DW-1:0]           fft_d8,
    input  logic [2*DW-1:0]           fft_d9,
    input  logic [2*DW-1:0]           fft_d10,
    input  logic [2*DW-1:0]           fft_d11,
    input  logic [2*DW-1:0]           fft_d12,
    input  logic [2*DW-1:0]           fft_d13,
    input  logic [2*DW-1:0]           fft_d14,
    input  logic [2*DW-1:0]           fft_d15,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NBIN)-1:0]   freq,
    output logic                      overrun
);
    import fas_pkg::*;
    localparam int IW = $clog2(NBIN);
    logic [2*DW-1:0] w_din  [NBIN];
    logic [2*DW-1:0] r_bank [NBIN];
    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            w_last;
    logic            w_accept;
    logic [DW-1:0]   w_re;
    logic [DW-1:0]   w_im;
    logic [MAGW-1:0] w_mag;
    logic [MAGW-1:0] r_mag;
    logic            r_v1;
    logic            r_first1;
    logic            r_last1;
    logic [IW-1:0]   r_idx1;
    logic [MAGW-1:0] r_max;
    logic [IW-1:0]   r_arg;
    logic            r_fin;
    logic            r_done;
    logic [IW-1:0]   r_freq;
    logic            r_ovr;
    assign w_din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                     fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
    assign w_last   = r_idx == IW'(NBIN - 1);
    assign in_ready = r_state == IDLE || w_last;
    assign busy     = r_state == CALC;
    assign w_accept = fft_valid && in_ready;
    assign done     = r_done;
    assign freq     = r_freq;
    assign overrun  = r_ovr;
    // Bank read is the pre-edge value, so a capture while reading bin 15 never corrupts it.
    assign w_re = r_bank[r_idx][RE_HI:RE_LO];
    assign w_im = r_bank[r_idx][IM_HI:IM_LO];
    fas_mag_sq u_mag (
        .i_re  (w_re),
        .i_im  (w_im),
        .o_mag (w_mag)
    );
    always_ff @(posedge clk) begin
        if (w_accept)
            for (int k = 0; k < NBIN; k++)
                r_bank[k] <= w_din[k];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_mag    <= '0;
            r_v1     <= 1'b0;
            r_first1 <= 1'b0;
            r_last1  <= 1'b0;
            r_idx1   <= '0;
            r_max    <= '0;
            r_arg    <= '0;
            r_fin    <= 1'b0;
            r_done   <= 1'b0;
            r_freq   <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_ovr <= fft_valid && !in_ready;
            if (w_accept) begin
                r_state <= CALC;
                r_idx   <= '0;
            end else if (r_state == CALC) begin
                r_state <= w_last ? IDLE : CALC;
                r_idx   <= r_idx + 1'b1;
            end
            r_v1     <= r_state == CALC;
            r_first1 <= r_idx == '0;
            r_last1  <= w_last;
            r_idx1   <= r_idx;
            r_mag    <= w_mag;
            // Strict compare keeps the lowest index on ties.
            if (r_v1 && (r_first1 || r_mag > r_max)) begin
                r_max <= r_mag;
                r_arg <= r_idx1;
            end
            r_fin  <= r_v1 && r_last1;
            r_done <= r_fin;
            if (r_fin)
                r_freq <= r_arg;
        end
    end
endmodule

// File: tb/tb_fas_peak_detect.sv
module tb_fas_peak_detect;
    typedef struct {
        logic [3:0] f;
        int         c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fft_valid = 1'b0;
    logic [31:0] fr [16];
    logic        in_ready, busy, done, overrun;
    logic [3:0]  freq;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fas_peak_detect dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(fr[0]), .fft_d1(fr[1]), .fft_d2(fr[2]), .fft_d3(fr[3]),
        .fft_d4(fr[4]), .fft_d5(fr[5]), .fft_d6(fr[6]), .fft_d7(fr[7]),
        .fft_d8(fr[8]), .fft_d9(fr[9]), .fft_d10(fr[10]), .fft_d11(fr[11]),
        .fft_d12(fr[12]), .fft_d13(fr[13]), .fft_d14(fr[14]), .fft_d15(fr[15]),
        .in_ready(in_ready), .busy(busy), .done(done), .freq(freq), .overrun(overrun)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", n, a, e);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int k = 0; k < 16; k++) fr[k] = v;
    endtask

    // Drives a frame at this negedge (accept on the next rising edge) and queues its result.
    task automatic offer(input logic [3:0] f, input bit expect_done);
        fft_valid = 1'b1;
        if (expect_done) q.push_back('{f: f, c: cyc + 1 + 18});
        @(negedge clk);
        fft_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("freq", freq, e.f);
                chk("done_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        fill(32'h0);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_freq", freq, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        @(negedge clk);

        fill(32'h0); fr[5] = 32'h0064_0000;
        offer(4'd5, 1);
        chk("busy_calc", busy, 1);
        drain();

        fill(32'h0); fr[3] = 32'hFF38_FF38; fr[12] = 32'h00FA_0000;
        offer(4'd3, 1);
        drain();

        fill(32'h0); fr[2] = 32'h0000_012C; fr[9] = 32'h0000_012C;
        offer(4'd2, 1);
        drain();

        fill(32'h0);
        offer(4'd0, 1);
        drain();

        fill(32'h7FFF_7FFF); fr[15] = 32'h8000_8000;
        offer(4'd15, 1);
        drain();

        fill(32'h0); fr[7] = 32'h0010_0010;
        offer(4'd7, 1);
        repeat (7) @(negedge clk);
        chk("ready_mid_calc", in_ready, 0);
        fill(32'h0); fr[3] = 32'h7000_7000;
        fft_valid = 1'b1;
        @(negedge clk);
        fft_valid = 1'b0;
        chk("overrun_pulse", overrun, 1);
        @(negedge clk);
        chk("overrun_clear", overrun, 0);
        repeat (6) @(negedge clk);
        chk("ready_idx15", in_ready, 1);
        fill(32'h0); fr[1] = 32'h0020_0000;
        offer(4'd1, 1);
        drain();

        fill(32'h0); fr[4] = 32'h0030_0000;
        offer(4'd4, 0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_freq", freq, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill(32'h0); fr[6] = 32'h0000_0040;
        offer(4'd6, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=%0d expected=0", q.size());
        $fatal(1, "timeout");
    end
endmodule
